// File: rtl/iob_split_n_pkg.sv
// Package: iob_split_n_pkg
// Shared definitions for the 1-master/N-slave native-bus splitter:
//   - state_t   : splitter FSM state encodings (IDLE/BUSY/ERR)
//   - ERR_RDATA : read data returned with an error response
//   - sel_width : width of the slave-select address field for a slave count
package iob_split_n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam int unsigned ERR_RDATA = 0;

    // Number of address bits needed to index n_slaves ports (at least 1).
    function automatic int sel_width(input int n_slaves);
        return (n_slaves <= 2) ? 1 : $clog2(n_slaves);
    endfunction

endpackage

// File: rtl/iob_split_wdog.sv
// Module: iob_split_wdog
// Transaction watchdog for the splitter. Counts BUSY cycles in which the
// selected slave has not answered; flags expiry when the count reaches
// all-ones. The count saturates there so the flag stays stable.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   clear    in  restart the count (new transaction accepted)
//   tick     in  one waiting cycle elapsed
//   expired  out count is all-ones
module iob_split_wdog #(
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_reg <= '0;
        end else if (tick && !(&cnt_reg)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign expired = &cnt_reg;

endmodule

// File: rtl/iob_split_n.sv
// Module: iob_split_n
// Parametrised 1-master/N-slave native-bus splitter. The request is
// registered on acceptance and the slave index, taken from
// addr[P_SLAVES -: SEL_W], is held for the whole transaction. Indices with
// no slave behind them get a one-cycle error response.
// Optional feature macro: IOB_SPLIT_TIMEOUT_EN adds a watchdog that ends a
// BUSY transaction with an error after 2**TIMEOUT_W-1 unanswered cycles.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   m_valid/m_addr/m_wdata/m_wstrb   master request (wstrb==0 means read)
//   m_rdata/m_ready/m_err      master response (rdata zero unless m_ready)
//   s_valid                    one-hot slave request
//   s_addr/s_wdata/s_wstrb     registered request, broadcast to slaves
//   s_rdata/s_ready            per-slave response, slave i at [i*DATA_W +: DATA_W]
module iob_split_n
    import iob_split_n_pkg::*;
#(
    parameter int N_SLAVES  = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int P_SLAVES  = 31,
    parameter int TIMEOUT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m_valid,
    input  logic [ADDR_W-1:0]        m_addr,
    input  logic [DATA_W-1:0]        m_wdata,
    input  logic [DATA_W/8-1:0]      m_wstrb,
    output logic [DATA_W-1:0]        m_rdata,
    output logic                     m_ready,
    output logic                     m_err,
    output logic [N_SLAVES-1:0]      s_valid,
    output logic [ADDR_W-1:0]        s_addr,
    output logic [DATA_W-1:0]        s_wdata,
    output logic [DATA_W/8-1:0]      s_wstrb,
    input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [N_SLAVES-1:0]      s_ready
);

    localparam int SEL_W = sel_width(N_SLAVES);

    // Reject configurations outside the supported range at elaboration.
    generate
        if (N_SLAVES < 2 || N_SLAVES > 16 || TIMEOUT_W < 1 ||
            P_SLAVES >= ADDR_W || P_SLAVES < SEL_W - 1 || DATA_W % 8 != 0) begin : g_bad_params
            $error("iob_split_n: illegal parameter combination");
        end
    endgenerate

    state_t              state_reg;
    logic [SEL_W-1:0]    sel_reg;
    logic [ADDR_W-1:0]   s_addr_reg;
    logic [DATA_W-1:0]   s_wdata_reg;
    logic [DATA_W/8-1:0] s_wstrb_reg;

    logic [SEL_W-1:0]    sel_field;
    logic                sel_ok;
    logic                busy;
    logic                capture;
    logic                ready_sel;
    logic                timeout_hit;
    logic [DATA_W-1:0]   rdata_mux;
    logic [DATA_W-1:0]   slave_data [N_SLAVES];

    assign sel_field = m_addr[P_SLAVES -: SEL_W];
    assign sel_ok    = int'(sel_field) < N_SLAVES;
    assign busy      = (state_reg == ST_BUSY);
    assign capture   = (state_reg == ST_IDLE) && m_valid;

    // s_valid is a pure decode of registered state, so it changes only on
    // clock edges. Each slave's read data is gated by its own select so the
    // OR-reduction below forms the read mux.
    generate
        for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_slave
            assign s_valid[gi]    = busy && (sel_reg == SEL_W'(gi));
            assign slave_data[gi] = s_valid[gi] ? s_rdata[gi*DATA_W +: DATA_W] : '0;
        end
    endgenerate

    always_comb begin
        rdata_mux = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            rdata_mux = rdata_mux | slave_data[i];
        end
    end

    // Only the selected slave's ready counts; others are masked by s_valid.
    assign ready_sel = |(s_ready & s_valid);

`ifdef IOB_SPLIT_TIMEOUT_EN
    logic wdog_expired;

    iob_split_wdog #(
        .CNT_W   (TIMEOUT_W)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (capture),
        .tick    (busy && !ready_sel),
        .expired (wdog_expired)
    );

    // A slave answer in the expiry cycle takes priority over the timeout.
    assign timeout_hit = busy && wdog_expired && !ready_sel;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            sel_reg     <= '0;
            s_addr_reg  <= '0;
            s_wdata_reg <= '0;
            s_wstrb_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (m_valid) begin
                        s_addr_reg  <= m_addr;
                        s_wdata_reg <= m_wdata;
                        s_wstrb_reg <= m_wstrb;
                        sel_reg     <= sel_field;
                        state_reg   <= sel_ok ? ST_BUSY : ST_ERR;
                    end
                end
                ST_BUSY: begin
                    if (ready_sel || timeout_hit) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_addr  = s_addr_reg;
    assign s_wdata = s_wdata_reg;
    assign s_wstrb = s_wstrb_reg;

    // Error responses (decode or timeout) complete with zero data.
    assign m_err   = (state_reg == ST_ERR) || timeout_hit;
    assign m_ready = ready_sel || m_err;
    assign m_rdata = ready_sel ? rdata_mux : DATA_W'(ERR_RDATA);

endmodule

// File: tb/tb_iob_split_n.sv
// Testbench: tb_iob_split_n
// Directed, table-driven checks of iob_split_n. A 4-slave instance covers
// normal transactions, back-to-back requests, address changes during BUSY
// and reset mid-transaction; a 3-slave instance covers the decode error and
// the long-wait / timeout behaviour (timeout only when IOB_SPLIT_TIMEOUT_EN).
module tb_iob_split_n;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    // 4-slave instance
    logic         m_valid = 1'b0;
    logic [31:0]  m_addr  = '0;
    logic [31:0]  m_wdata = '0;
    logic [3:0]   m_wstrb = '0;
    logic [31:0]  m_rdata;
    logic         m_ready;
    logic         m_err;
    logic [3:0]   s_valid;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic [127:0] s_rdata = '0;
    logic [3:0]   s_ready = '0;

    // 3-slave instance
    logic         b_m_valid = 1'b0;
    logic [31:0]  b_m_addr  = '0;
    logic [31:0]  b_m_wdata = '0;
    logic [3:0]   b_m_wstrb = '0;
    logic [31:0]  b_m_rdata;
    logic         b_m_ready;
    logic         b_m_err;
    logic [2:0]   b_s_valid;
    logic [31:0]  b_s_addr;
    logic [31:0]  b_s_wdata;
    logic [3:0]   b_s_wstrb;
    logic [95:0]  b_s_rdata = '0;
    logic [2:0]   b_s_ready = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iob_split_n #(
        .N_SLAVES(4), .ADDR_W(32), .DATA_W(32), .P_SLAVES(31), .TIMEOUT_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready)
    );

    iob_split_n #(
        .N_SLAVES(3), .ADDR_W(32), .DATA_W(32), .P_SLAVES(31), .TIMEOUT_W(4)
    ) dut3 (
        .clk(clk), .rst(rst),
        .m_valid(b_m_valid), .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_wstrb(b_m_wstrb),
        .m_rdata(b_m_rdata), .m_ready(b_m_ready), .m_err(b_m_err),
        .s_valid(b_s_valid), .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb),
        .s_rdata(b_s_rdata), .s_ready(b_s_ready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          wait_cyc;
        logic [31:0] rdata;
        int          slave;
        logic [3:0]  exp_sv;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive point: just after the rising edge. Sample point: falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_rdata(input int sel, input logic [31:0] val);
        for (int i = 0; i < 4; i++) begin
            s_rdata[i*32 +: 32] = (i == sel) ? val : (32'hDEAD_0000 | 32'(i));
        end
    endtask

    // One complete transaction on the 4-slave instance.
    task automatic do_txn(input int idx, input vec_t v);
        int errs_before;
        errs_before = n_fail;
        tick();
        m_valid = 1'b1; m_addr = v.addr; m_wdata = v.wdata; m_wstrb = v.wstrb;
        s_ready = 4'b0000;
        set_rdata(v.slave, v.rdata);
        mid();
        check("idle_m_ready", 32'(m_ready), 32'd0);
        check("idle_s_valid", 32'(s_valid), 32'd0);
        for (int i = 0; i < v.wait_cyc; i++) begin
            tick();
            s_ready = ~v.exp_sv;
            mid();
            check("wait_s_valid", 32'(s_valid), 32'(v.exp_sv));
            check("wait_m_ready", 32'(m_ready), 32'd0);
            check("wait_m_rdata", m_rdata, 32'd0);
        end
        tick();
        s_ready = v.exp_sv;
        mid();
        check("done_s_valid", 32'(s_valid), 32'(v.exp_sv));
        check("done_m_ready", 32'(m_ready), 32'd1);
        check("done_m_err",   32'(m_err), 32'd0);
        check("done_m_rdata", m_rdata, v.rdata);
        check("done_s_addr",  s_addr, v.addr);
        check("done_s_wdata", s_wdata, v.wdata);
        check("done_s_wstrb", 32'(s_wstrb), 32'(v.wstrb));
        tick();
        m_valid = 1'b0; s_ready = 4'b0000;
        mid();
        check("after_s_valid", 32'(s_valid), 32'd0);
        check("after_m_ready", 32'(m_ready), 32'd0);
        $display("txn %0d addr=0x%08h wstrb=0x%0h wait=%0d rdata=0x%08h errors=%0d",
                 idx, v.addr, v.wstrb, v.wait_cyc, m_rdata, n_fail - errs_before);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int pulses;
        logic [3:0] exp_pat;

        // addr, wdata, wstrb, wait, rdata, slave, s_valid
        vecs[0] = '{32'h4000_0010, 32'h0000_0000, 4'h0, 3, 32'hCAFE_0001, 1, 4'b0010};
        vecs[1] = '{32'h0000_0100, 32'h1234_5678, 4'hF, 0, 32'h1111_2222, 0, 4'b0001};
        vecs[2] = '{32'h8000_0004, 32'hA5A5_5A5A, 4'h3, 1, 32'hB0B0_B0B0, 2, 4'b0100};
        vecs[3] = '{32'hC000_FFFC, 32'h0000_0000, 4'h0, 2, 32'h5555_AAAA, 3, 4'b1000};
        vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 4'h0, 0, 32'hFFFF_FFFF, 3, 4'b1000};
        vecs[5] = '{32'h3FFF_FFFF, 32'hDEAD_BEEF, 4'h8, 0, 32'h0000_0001, 0, 4'b0001};

        // Reset state
        set_rdata(0, 32'h9999_9999);
        tick();
        tick();
        mid();
        check("rst_s_valid", 32'(s_valid), 32'd0);
        check("rst_m_ready", 32'(m_ready), 32'd0);
        check("rst_m_err",   32'(m_err), 32'd0);
        check("rst_m_rdata", m_rdata, 32'd0);
        check("rst_s_addr",  s_addr, 32'd0);
        check("rst_b_s_valid", 32'(b_s_valid), 32'd0);
        check("rst_b_m_ready", 32'(b_m_ready), 32'd0);
        tick();
        rst = 1'b0;

        // Table-driven single transactions
        for (int i = 0; i < 6; i++) begin
            do_txn(i, vecs[i]);
        end

        // Back-to-back: m_valid held 4 cycles, zero-wait slave 0
        tick();
        m_valid = 1'b1; m_addr = 32'h0000_0020; m_wdata = 32'h0BAD_F00D; m_wstrb = 4'hF;
        s_ready = 4'b0001;
        set_rdata(0, 32'h0000_0077);
        exp_pat = 4'b1010;  // m_ready per cycle, cycle 0 in bit 0
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            mid();
            check("b2b_m_ready", 32'(m_ready), 32'(exp_pat[c]));
            if (m_ready) pulses++;
        end
        tick();
        m_valid = 1'b0; s_ready = 4'b0000;
        mid();
        check("b2b_end_m_ready", 32'(m_ready), 32'd0);
        check("b2b_pulses", 32'(pulses), 32'd2);
        $display("txn b2b pulses=%0d", pulses);

        // Address change during BUSY; non-selected slave ready ignored
        tick();
        m_valid = 1'b1; m_addr = 32'h4000_0000; m_wstrb = 4'h0;
        s_ready = 4'b0000;
        set_rdata(1, 32'h1234_0004);
        mid();
        for (int c = 0; c < 2; c++) begin
            tick();
            m_addr = 32'h8000_0000; s_ready = 4'b0100;
            mid();
            check("chg_s_valid", 32'(s_valid), 32'h2);
            check("chg_m_ready", 32'(m_ready), 32'd0);
            check("chg_s_addr",  s_addr, 32'h4000_0000);
        end
        tick();
        s_ready = 4'b0010;
        mid();
        check("chg_done_m_ready", 32'(m_ready), 32'd1);
        check("chg_done_m_rdata", m_rdata, 32'h1234_0004);
        tick();
        m_valid = 1'b0; s_ready = 4'b0000;
        mid();
        check("chg_end_m_ready", 32'(m_ready), 32'd0);
        $display("txn addr_change s_addr=0x%08h", s_addr);

        // Reset during BUSY
        tick();
        m_valid = 1'b1; m_addr = 32'h8000_0040; m_wdata = 32'h0F0F_0F0F; m_wstrb = 4'h3;
        set_rdata(2, 32'h2222_0002);
        mid();
        tick();
        mid();
        check("rstb_busy_s_valid", 32'(s_valid), 32'h4);
        tick();
        rst = 1'b1;
        mid();
        check("rstb_m_ready", 32'(m_ready), 32'd0);
        tick();
        rst = 1'b0; m_valid = 1'b0;
        mid();
        check("rstb_s_valid", 32'(s_valid), 32'd0);
        check("rstb_m_ready_after", 32'(m_ready), 32'd0);
        check("rstb_m_err",   32'(m_err), 32'd0);
        check("rstb_m_rdata", m_rdata, 32'd0);
        check("rstb_s_addr",  s_addr, 32'd0);
        check("rstb_s_wdata", s_wdata, 32'd0);
        check("rstb_s_wstrb", 32'(s_wstrb), 32'd0);
        tick();
        mid();
        check("rstb_no_late_ready", 32'(m_ready), 32'd0);
        $display("txn reset_mid_busy");
        do_txn(6, vecs[0]);

        // Decode error on the 3-slave instance (field = 3)
        tick();
        b_m_valid = 1'b1; b_m_addr = 32'hC000_0000; b_m_wstrb = 4'h0;
        b_s_rdata = {96{1'b1}};
        b_s_ready = 3'b111;
        mid();
        check("derr_idle_m_ready", 32'(b_m_ready), 32'd0);
        check("derr_idle_s_valid", 32'(b_s_valid), 32'd0);
        tick();
        mid();
        check("derr_m_ready", 32'(b_m_ready), 32'd1);
        check("derr_m_err",   32'(b_m_err), 32'd1);
        check("derr_m_rdata", b_m_rdata, 32'd0);
        check("derr_s_valid", 32'(b_s_valid), 32'd0);
        tick();
        b_m_valid = 1'b0; b_s_ready = 3'b000;
        mid();
        check("derr_end_m_ready", 32'(b_m_ready), 32'd0);
        check("derr_end_m_err",   32'(b_m_err), 32'd0);
        $display("txn decode_error addr=0xC0000000");

        // Highest mapped slave on the 3-slave instance, zero wait
        tick();
        b_m_valid = 1'b1; b_m_addr = 32'h8000_0000;
        b_s_rdata = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
        b_s_ready = 3'b100;
        mid();
        check("s2_idle_m_ready", 32'(b_m_ready), 32'd0);
        tick();
        mid();
        check("s2_s_valid", 32'(b_s_valid), 32'h4);
        check("s2_m_ready", 32'(b_m_ready), 32'd1);
        check("s2_m_err",   32'(b_m_err), 32'd0);
        check("s2_m_rdata", b_m_rdata, 32'h3333_0002);
        tick();
        b_m_valid = 1'b0; b_s_ready = 3'b000;
        mid();
        check("s2_end_s_valid", 32'(b_s_valid), 32'd0);
        $display("txn n3_slave2 rdata ok");

        // Slave 1 never answers on its own line
        tick();
        b_m_valid = 1'b1; b_m_addr = 32'h4000_0000;
        b_s_rdata = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
        b_s_ready = 3'b101;
        mid();
`ifdef IOB_SPLIT_TIMEOUT_EN
        for (int k = 1; k <= 15; k++) begin
            tick();
            mid();
            check("to_wait_m_ready", 32'(b_m_ready), 32'd0);
            check("to_wait_s_valid", 32'(b_s_valid), 32'h2);
        end
        tick();
        mid();
        check("to_m_ready", 32'(b_m_ready), 32'd1);
        check("to_m_err",   32'(b_m_err), 32'd1);
        check("to_m_rdata", b_m_rdata, 32'd0);
        tick();
        b_m_valid = 1'b0; b_s_ready = 3'b000;
        mid();
        check("to_end_s_valid", 32'(b_s_valid), 32'd0);
        check("to_end_m_ready", 32'(b_m_ready), 32'd0);
        $display("txn timeout after 15 busy cycles");
`else
        for (int k = 1; k <= 20; k++) begin
            tick();
            mid();
            check("hold_m_ready", 32'(b_m_ready), 32'd0);
            check("hold_s_valid", 32'(b_s_valid), 32'h2);
        end
        tick();
        b_s_ready = 3'b010;
        mid();
        check("hold_done_m_ready", 32'(b_m_ready), 32'd1);
        check("hold_done_m_err",   32'(b_m_err), 32'd0);
        check("hold_done_m_rdata", b_m_rdata, 32'h3333_0001);
        tick();
        b_m_valid = 1'b0; b_s_ready = 3'b000;
        mid();
        check("hold_end_s_valid", 32'(b_s_valid), 32'd0);
        $display("txn long_wait 20 cycles then slave1 ready");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
